frame_streamer: RTL
===================

# frame_streamer

Transmitting end of the display-controller command stream: reads a frame out of pixel memory and serialises it into the byte command protocol consumed by the display data loader, i.e. per row a load-row header byte followed by every column's pixel word, then a single flip byte. Sits between a frame source (framebuffer or test-pattern RAM) and a byte transport (UART/SPI transmitter or a direct loopback into the loader), with valid/ready backpressure on the byte side.

## Interface
- segments, 1, pixel segments per memory word; word = segments*3 bytes
- rows, 8, addressable rows, 1..16 (row index must fit the 4-bit header nibble)
- columns, 32, columns per row, >=1
- bitwidth, 8, bits per colour channel; must be 8 (one channel per byte)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to stream one frame; ignored while busy
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the flip byte is accepted
- ren  out  1  memory read enable
- rrow  out  $clog2(rows)  memory read row
- rcol  out  $clog2(columns)  memory read column
- rdata  in  segments*24  read data, valid exactly one cycle after ren
- odata  out  8  output byte
- ovalid  out  1  odata valid
- oready  in  1  sink accepts; transfer when ovalid && oready on a rising edge

## Operation
- Byte sequence per frame: for row r = 0..rows-1: header 0xF0|r, then columns words in column order 0..columns-1, each sent most-significant byte first (rdata[W-1:W-8] first, W = segments*24); after last row: 0x10.
- Total bytes = rows*(1 + columns*segments*3) + 1; defaults give 777.
- States: IDLE, HDR, FETCH, LATCH, DATA, FLIP.
  - IDLE: busy=0; start=1 -> HDR with row=0, col=0.
  - HDR: ovalid=1, odata=0xF0|row; on transfer -> FETCH.
  - FETCH: ren=1, rrow=row, rcol=col for one cycle -> LATCH.
  - LATCH: capture rdata into shift register, byte counter=0 -> DATA.
  - DATA: ovalid=1, odata=shift[W-1:W-8]; on transfer shift left 8, counter+1; after byte segments*3-1: if col<columns-1 then col+1 -> FETCH; else if row<rows-1 then row+1, col=0 -> HDR; else -> FLIP.
  - FLIP: ovalid=1, odata=0x10; on transfer -> IDLE, done=1 for one cycle.
- AXI-style rules: once ovalid is high, odata and ovalid hold until transfer; ovalid never drops without a transfer (except reset).
- ren is only asserted in FETCH; rrow/rcol hold their last value otherwise.
- start while busy is ignored, with no queuing. start in the same cycle as done is accepted as a new frame, because the state is then IDLE.

## Timing
- Reset (async assert): odata=0, ovalid=0, ren=0, rrow=0, rcol=0, busy=0, done=0, state IDLE. Reset mid-frame abandons the frame immediately; no flip byte is sent.
- start sampled at edge N -> at N+1: busy=1, ovalid=1, odata=0xF0.
- Header transfer at edge T -> ren=1 during T..T+1; rdata captured at T+2; first data byte valid after T+2; with oready tied high, that byte transfers at T+3.
- Per word overhead: 2 non-valid cycles (FETCH, LATCH). With oready tied high, a frame takes rows*(1 + columns*(segments*3+2)) + 1 byte-side cycles from the first header.
- done pulses in the cycle after the 0x10 transfer, and busy falls in that same cycle.

## Test plan
- rows=2, columns=2, segments=1, memory word(r,c)=0x{r}{c}AABB-style pattern, oready=1 -> exactly 0xF0, 3 bytes, 3 bytes, 0xF1, 3 bytes, 3 bytes, 0x10 (15 bytes), MSB first, done once.
- Random oready with 30% stalls -> odata stable and ovalid held during every stall; byte stream identical to the no-stall run.
- Loopback into data loader (defaults, rows=8, columns=32) -> 777 bytes; loader memory matches source; loaded pulses once.
- start pulsed again mid-frame and on the done cycle -> the mid-frame start is ignored; the start on the done cycle begins a second frame with 0xF0 next cycle.
- rst asserted while in DATA -> ovalid=0 and busy=0 immediately with no clock edge; next start restarts at 0xF0.
- segments=2 -> 6 bytes per column; ren asserted exactly columns times per row, with rcol incrementing 0..columns-1.

Source files
------------

// File: rtl/frame_streamer.sv
// Serialises a frame from pixel memory into row-header / pixel-byte / flip command bytes.
// Two idle byte-side cycles per memory word (fetch, latch); odata/ovalid hold under oready stalls.
module frame_streamer #(
    parameter int segments = 1,
    parameter int rows     = 8,
    parameter int columns  = 32,
    parameter int bitwidth = 8,
    localparam int RW = (rows > 1) ? $clog2(rows) : 1,
    localparam int CW = (columns > 1) ? $clog2(columns) : 1,
    localparam int W  = segments * 3 * bitwidth
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          ren,
    output logic [RW-1:0] rrow,
    output logic [CW-1:0] rcol,
    input  logic [W-1:0]  rdata,
    output logic [7:0]    odata,
    output logic          ovalid,
    input  logic          oready
);
    localparam int NB = segments * 3;
    localparam int BW = $clog2(NB);

    typedef enum logic [2:0] {IDLE, HDR, FETCH, LATCH, DATA, FLIP} state_t;

    state_t        state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [BW-1:0] cnt;
    // The top byte of a word goes straight to odata, so only the remainder is shifted.
    logic [W-9:0]  shift;
    logic          xfer;

    assign xfer = ovalid && oready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            row    <= '0;
            col    <= '0;
            cnt    <= '0;
            shift  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            ren    <= 1'b0;
            rrow   <= '0;
            rcol   <= '0;
            odata  <= 8'h00;
            ovalid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= HDR;
                        busy   <= 1'b1;
                        row    <= '0;
                        col    <= '0;
                        odata  <= 8'hF0;
                        ovalid <= 1'b1;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        state  <= FETCH;
                        ovalid <= 1'b0;
                        ren    <= 1'b1;
                        rrow   <= row;
                        rcol   <= col;
                    end
                end
                FETCH: begin
                    state <= LATCH;
                    ren   <= 1'b0;
                end
                LATCH: begin
                    state  <= DATA;
                    shift  <= rdata[W-9:0];
                    odata  <= rdata[W-1 -: 8];
                    ovalid <= 1'b1;
                    cnt    <= '0;
                end
                DATA: begin
                    if (xfer) begin
                        cnt   <= cnt + 1'b1;
                        shift <= shift << 8;
                        odata <= shift[W-9 -: 8];
                        if (cnt == BW'(NB - 1)) begin
                            if (col != CW'(columns - 1)) begin
                                state  <= FETCH;
                                col    <= col + 1'b1;
                                ovalid <= 1'b0;
                                ren    <= 1'b1;
                                rrow   <= row;
                                rcol   <= col + 1'b1;
                            end else if (row != RW'(rows - 1)) begin
                                state <= HDR;
                                row   <= row + 1'b1;
                                col   <= '0;
                                odata <= 8'hF0 | 8'(row + 1'b1);
                            end else begin
                                state <= FLIP;
                                odata <= 8'h10;
                            end
                        end
                    end
                end
                FLIP: begin
                    if (xfer) begin
                        state  <= IDLE;
                        ovalid <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
